// File: rtl/tx_uart_param_pkg.sv
// Shared encodings for the parametrised serial transmitter.
package tx_uart_param_pkg;

  // Parity selection values for the PARITY parameter
  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // Transmit FSM states, one per serial field of a frame
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

endpackage

// File: rtl/tx_uart_param_fifo.sv
// Small synchronous FIFO queuing words ahead of the transmitter.
// Full/empty come from an extra pointer MSB; read data is combinational.
module tx_uart_param_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointer registers; callers only push when not full and pop when not empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/tx_uart_param.sv
// Parametrised async serial transmitter with an input FIFO.
// Frame: start(0), DATA_BITS LSB first, optional parity, STOP_BITS high.
module tx_uart_param
  import tx_uart_param_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_pi,
  output logic                 tx_so,
  output logic                 tx_busy,
  output logic                 tx_full,
  output logic                 tx_ovf
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          PAR_INV   = (PARITY == PARITY_ODD);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("tx_uart_param: BAUD_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("tx_uart_param: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("tx_uart_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("tx_uart_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tx_uart_param: FIFO_DEPTH must be a power of 2, >= 2");
  end

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 start_q, ovf_q;
  logic                 push_req, push, pop, load, cnt_last;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  // Full check uses the registered flag only; a same-cycle pop does not help
  assign push_req = tx_start & ~start_q;
  assign push     = push_req & ~tx_full;

  tx_uart_param_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(tx_pi),
    .pop  (pop),
    .rdata(fifo_rdata),
    .full (tx_full),
    .empty(fifo_empty)
  );

  // Rising-edge detect on tx_start and the one-cycle overflow pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      start_q <= tx_start;
      ovf_q   <= push_req & tx_full;
    end
  end

  // FSM state plus bit-period counter, field counter and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  // Next-state and serial output; load pops the FIFO and starts a new frame
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    pop      = 1'b0;
    load     = 1'b0;
    tx_so    = 1'b1;
    cnt_last = (cnt_q == CNT_LAST);

    if (state_q != StIdle) begin
      cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
    end

    unique case (state_q)
      StIdle: begin
        load = ~fifo_empty;
      end
      StStart: begin
        tx_so = 1'b0;
        if (cnt_last) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        tx_so = shift_q[0];
        if (cnt_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? StParity : StStop;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      StParity: begin
        tx_so = par_q;
        if (cnt_last) begin
          state_d = StStop;
          bit_d   = '0;
        end
      end
      StStop: begin
        if (cnt_last) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = StIdle;
            load    = ~fifo_empty;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Back-to-back frames go straight from the last stop bit into START
    if (load) begin
      pop     = 1'b1;
      shift_d = fifo_rdata;
      par_d   = (^fifo_rdata) ^ PAR_INV;
      state_d = StStart;
      cnt_d   = '0;
    end
  end

  assign tx_busy = (state_q != StIdle) | ~fifo_empty;
  assign tx_ovf  = ovf_q;

endmodule
